sd_sector_loader: RTL and testbench

Multi-sector SD-card read engine for loading initial boards and pattern data. It sits between `sd_controller` (SPI mode, 25 MHz domain) and a downstream word FIFO. On a start pulse it reads `num_sectors` consecutive 512-byte sectors, detects each new byte, packs bytes into `DATA_W`-bit words and writes them into the FIFO. It only issues a sector read when the FIFO has room for the whole sector, because the controller cannot be stalled mid-sector.

---
 rtl/sd_sector_loader.sv | 198 +++++++++++++++++++
 tb/tb_sd_sector_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_loader.sv
// Multi-sector SD read engine: packs controller bytes into DATA_W-bit FIFO words, one whole sector at a time.
// Optional running byte checksum output enabled by defining SD_LOADER_CHECKSUM_EN.
module sd_sector_loader #(
    parameter int DATA_W     = 8,
    parameter int SPACE_W    = 10,
    parameter int ADDR_SHIFT = 9,
    parameter int MSB_FIRST  = 1,
    parameter int TIMEOUT    = 1048575
) (
    input  logic               clk_25mhz,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        start_sector,
    input  logic [15:0]        num_sectors,
    input  logic               sd_ready,
    output logic               sd_rd,
    output logic [31:0]        sd_addr,
    input  logic [7:0]         sd_dout,
    input  logic               sd_byte_available,
    input  logic [SPACE_W-1:0] fifo_space,
    output logic               fifo_wr_en,
    output logic [DATA_W-1:0]  fifo_din,
    output logic               busy,
    output logic               done,
    output logic               error
`ifdef SD_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]        checksum
`endif
);

    localparam int BPW   = DATA_W / 8;
    localparam int WPS   = 512 / BPW;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0]      WPS_U   = 32'(WPS);
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(BPW - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_SPACE, S_WAIT_READY, S_ISSUE, S_READ, S_FINISH, S_ERROR
    } state_t;

    state_t             state;
    logic [31:0]        sec;
    logic [15:0]        remaining;
    logic [8:0]         byte_cnt;
    logic [IDX_W-1:0]   byte_idx;
    logic [DATA_W-1:0]  pack;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               byte_q;

    logic               byte_edge;
    logic               space_ok;
    logic               tmo_run;
    logic               progress;
    logic [IDX_W-1:0]   lane_sel;
    logic [DATA_W-1:0]  word_nxt;

    // Drop one byte into the selected 8-bit lane of a partially packed word.
    function automatic logic [DATA_W-1:0] insert_byte(input logic [DATA_W-1:0] w,
                                                      input logic [IDX_W-1:0]  lane,
                                                      input logic [7:0]        b);
        logic [DATA_W-1:0] r;
        r = w;
        for (int i = 0; i < BPW; i++) begin
            if (lane == IDX_W'(i)) r[i*8 +: 8] = b;
        end
        return r;
    endfunction

    always_comb begin
        byte_edge = sd_byte_available & ~byte_q;
        space_ok  = (32'(fifo_space) >= WPS_U);
        lane_sel  = (MSB_FIRST != 0) ? (LAST_IX - byte_idx) : byte_idx;
        word_nxt  = insert_byte(pack, lane_sel, sd_dout);
        tmo_run   = (state == S_WAIT_READY) || (state == S_ISSUE) ||
                    (state == S_READ) || (state == S_FINISH);
        // Any forward motion restarts the idle window.
        progress  = ((state == S_WAIT_READY) &&  sd_ready) ||
                    ((state == S_ISSUE)      && !sd_ready) ||
                    ((state == S_READ)       &&  byte_edge) ||
                    ((state == S_FINISH)     &&  sd_ready);
    end

    always_ff @(posedge clk_25mhz) begin
        fifo_wr_en <= 1'b0;
        done       <= 1'b0;
        if (reset) begin
            state     <= S_IDLE;
            sd_rd     <= 1'b0;
            sd_addr   <= '0;
            fifo_din  <= '0;
            busy      <= 1'b0;
            error     <= 1'b0;
            sec       <= '0;
            remaining <= '0;
            byte_cnt  <= '0;
            byte_idx  <= '0;
            pack      <= '0;
            tmo_cnt   <= '0;
            byte_q    <= 1'b0;
`ifdef SD_LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            byte_q <= sd_byte_available;
            case (state)
                S_IDLE: begin
                    // busy drops one cycle after done, so a start landing on done is ignored
                    busy <= 1'b0;
                    if (start && !busy) begin
                        sec       <= start_sector;
                        remaining <= num_sectors;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_START;
`ifdef SD_LOADER_CHECKSUM_EN
                        checksum  <= '0;
`endif
                    end
                end
                S_START: begin
                    if (remaining == 16'd0) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT_SPACE;
                    end
                end
                S_WAIT_SPACE: begin
                    if (space_ok) state <= S_WAIT_READY;
                end
                S_WAIT_READY: begin
                    if (sd_ready) begin
                        sd_rd   <= 1'b1;
                        sd_addr <= sec << ADDR_SHIFT;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!sd_ready) begin
                        sd_rd    <= 1'b0;
                        byte_cnt <= '0;
                        byte_idx <= '0;
                        pack     <= '0;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (byte_edge) begin
                        pack     <= word_nxt;
                        byte_cnt <= byte_cnt + 9'd1;
`ifdef SD_LOADER_CHECKSUM_EN
                        checksum <= checksum + {8'h00, sd_dout};
`endif
                        if (byte_idx == LAST_IX) begin
                            fifo_wr_en <= 1'b1;
                            fifo_din   <= word_nxt;
                            byte_idx   <= '0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                        if (byte_cnt == 9'd511) begin
                            sec       <= sec + 32'd1;
                            remaining <= remaining - 16'd1;
                            state     <= (remaining == 16'd1) ? S_FINISH : S_WAIT_SPACE;
                        end
                    end
                end
                S_FINISH: begin
                    if (sd_ready) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Watchdog on controller activity; overrides the state update above on expiry.
            if (!tmo_run || progress) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_MAX) begin
                tmo_cnt <= '0;
                state   <= S_ERROR;
                sd_rd   <= 1'b0;
                busy    <= 1'b0;
                error   <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_loader.sv
// Directed bench for sd_sector_loader: three instances (8-bit, 32-bit MSB-first, 32-bit LSB-first block-addressed) share one SD model.
module tb_sd_sector_loader;

    logic        clk_25mhz = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_sector = '0;
    logic [15:0] num_sectors = '0;
    logic        sd_ready = 1'b1;
    logic [7:0]  sd_dout = '0;
    logic        sd_byte_available = 1'b0;
    logic [9:0]  fifo_space = 10'd512;

    logic        sd_rd_a, sd_rd_b, sd_rd_c;
    logic [31:0] sd_addr_a, sd_addr_b, sd_addr_c;
    logic        fifo_wr_en_a, fifo_wr_en_b, fifo_wr_en_c;
    logic [7:0]  fifo_din_a;
    logic [31:0] fifo_din_b, fifo_din_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        error_a, error_b, error_c;
`ifdef SD_LOADER_CHECKSUM_EN
    logic [15:0] checksum_a, checksum_b, checksum_c;
`endif

    int pass_cnt = 0;
    int check_cnt = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    sd_sector_loader #(.DATA_W(8), .SPACE_W(10), .ADDR_SHIFT(9), .MSB_FIRST(1), .TIMEOUT(1000)) dut_a (
        .clk_25mhz(clk_25mhz), .reset(reset), .start(start), .start_sector(start_sector),
        .num_sectors(num_sectors), .sd_ready(sd_ready), .sd_rd(sd_rd_a), .sd_addr(sd_addr_a),
        .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .fifo_space(fifo_space),
        .fifo_wr_en(fifo_wr_en_a), .fifo_din(fifo_din_a), .busy(busy_a), .done(done_a), .error(error_a)
`ifdef SD_LOADER_CHECKSUM_EN
        , .checksum(checksum_a)
`endif
    );

    sd_sector_loader #(.DATA_W(32), .SPACE_W(10), .ADDR_SHIFT(9), .MSB_FIRST(1), .TIMEOUT(1000)) dut_b (
        .clk_25mhz(clk_25mhz), .reset(reset), .start(start), .start_sector(start_sector),
        .num_sectors(num_sectors), .sd_ready(sd_ready), .sd_rd(sd_rd_b), .sd_addr(sd_addr_b),
        .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .fifo_space(fifo_space),
        .fifo_wr_en(fifo_wr_en_b), .fifo_din(fifo_din_b), .busy(busy_b), .done(done_b), .error(error_b)
`ifdef SD_LOADER_CHECKSUM_EN
        , .checksum(checksum_b)
`endif
    );

    sd_sector_loader #(.DATA_W(32), .SPACE_W(10), .ADDR_SHIFT(0), .MSB_FIRST(0), .TIMEOUT(1000)) dut_c (
        .clk_25mhz(clk_25mhz), .reset(reset), .start(start), .start_sector(start_sector),
        .num_sectors(num_sectors), .sd_ready(sd_ready), .sd_rd(sd_rd_c), .sd_addr(sd_addr_c),
        .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .fifo_space(fifo_space),
        .fifo_wr_en(fifo_wr_en_c), .fifo_din(fifo_din_c), .busy(busy_c), .done(done_c), .error(error_c)
`ifdef SD_LOADER_CHECKSUM_EN
        , .checksum(checksum_c)
`endif
    );

    // Output recorders
    logic [7:0]  w8 [0:4095];
    logic [31:0] wm [0:1023];
    logic [31:0] wl [0:1023];
    int n8 = 0, nm = 0, nl = 0, rd_rises = 0, done_cnt = 0;
    logic rd_prev = 1'b0;

    always @(negedge clk_25mhz) begin
        if (fifo_wr_en_a === 1'b1) begin w8[n8[11:0]] = fifo_din_a; n8++; end
        if (fifo_wr_en_b === 1'b1) begin wm[nm[9:0]] = fifo_din_b; nm++; end
        if (fifo_wr_en_c === 1'b1) begin wl[nl[9:0]] = fifo_din_c; nl++; end
        if (sd_rd_a === 1'b1 && rd_prev !== 1'b1) rd_rises++;
        rd_prev = sd_rd_a;
        if (done_a === 1'b1) done_cnt++;
    end

    logic [31:0] a8, al;
    bit          ok, seen;

    task automatic pulse_start(input logic [31:0] s, input logic [15:0] n);
        @(negedge clk_25mhz);
        start_sector = s;
        num_sectors  = n;
        start        = 1'b1;
        @(negedge clk_25mhz);
        start = 1'b0;
    endtask

    task automatic send_bytes(input int mode, input int count);
        for (int k = 0; k < count; k++) begin
            case (mode)
                0:       sd_dout = 8'(k);
                1:       sd_dout = 8'(8'h11 * ((k % 4) + 1));
                default: sd_dout = 8'hFF;
            endcase
            sd_byte_available = 1'b1;
            @(negedge clk_25mhz);
            @(negedge clk_25mhz);
            sd_byte_available = 1'b0;
            @(negedge clk_25mhz);
            @(negedge clk_25mhz);
        end
    endtask

    task automatic wait_rd(output bit found);
        int cnt = 0;
        while (sd_rd_a !== 1'b1 && cnt < 5000) begin @(negedge clk_25mhz); cnt++; end
        found = (sd_rd_a === 1'b1);
    endtask

    task automatic serve_sector(input int mode, output logic [31:0] addr8, output logic [31:0] addrl,
                                output bit found);
        wait_rd(found);
        addr8 = sd_addr_a;
        addrl = sd_addr_c;
        if (found) begin
            sd_ready = 1'b0;
            @(negedge clk_25mhz);
            send_bytes(mode, 512);
            sd_ready = 1'b1;
        end
    endtask

    task automatic wait_done(output bit found);
        int cnt = 0;
        found = 1'b0;
        while (!found && cnt < 200) begin
            @(negedge clk_25mhz);
            cnt++;
            if (done_a === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk_25mhz);
        check_cnt++; if (sd_rd_a !== 1'b0) $display("FAIL reset_sd_rd: got %b want 0", sd_rd_a); else pass_cnt++;
        check_cnt++; if (sd_addr_a !== 32'h0) $display("FAIL reset_sd_addr: got %h want 0", sd_addr_a); else pass_cnt++;
        check_cnt++; if (fifo_wr_en_a !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en_a); else pass_cnt++;
        check_cnt++; if (fifo_din_a !== 8'h0) $display("FAIL reset_din8: got %h want 0", fifo_din_a); else pass_cnt++;
        check_cnt++; if ({busy_a, done_a, error_a} !== 3'b000) $display("FAIL reset_flags_a: got %b want 000", {busy_a, done_a, error_a}); else pass_cnt++;
        check_cnt++; if ({busy_b, done_b, error_b, sd_rd_b, busy_c, done_c, error_c, sd_rd_c} !== 8'h00)
            $display("FAIL reset_flags_bc: got %b want 00000000", {busy_b, done_b, error_b, sd_rd_b, busy_c, done_c, error_c, sd_rd_c}); else pass_cnt++;
        check_cnt++; if ({fifo_din_b, fifo_din_c, sd_addr_b, sd_addr_c} !== 128'h0) $display("FAIL reset_data_bc: got nonzero want 0"); else pass_cnt++;
`ifdef SD_LOADER_CHECKSUM_EN
        check_cnt++; if (checksum_a !== 16'h0) $display("FAIL reset_checksum: got %h want 0", checksum_a); else pass_cnt++;
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk_25mhz);
    endtask

    task automatic test_single_sector;
        int b8 = n8, bm = nm, bl = nl, brd = rd_rises, bd = done_cnt, bad = 0;
        pulse_start(32'd15, 16'd1);
        check_cnt++; if (busy_a !== 1'b1) $display("FAIL single_busy_rise: got %b want 1", busy_a); else pass_cnt++;
        serve_sector(0, a8, al, ok);
        check_cnt++; if (ok !== 1'b1) $display("FAIL single_rd_issued: got %b want 1", ok); else pass_cnt++;
        check_cnt++; if (a8 !== 32'h1E00) $display("FAIL single_addr_sdsc: got %h want 00001e00", a8); else pass_cnt++;
        check_cnt++; if (al !== 32'd15) $display("FAIL single_addr_sdhc: got %h want 0000000f", al); else pass_cnt++;
        wait_done(seen);
        check_cnt++; if (seen !== 1'b1) $display("FAIL single_done: got %b want 1", seen); else pass_cnt++;
        check_cnt++; if (busy_a !== 1'b1) $display("FAIL single_busy_at_done: got %b want 1", busy_a); else pass_cnt++;
        @(negedge clk_25mhz);
        check_cnt++; if (busy_a !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy_a); else pass_cnt++;
        repeat (3) @(negedge clk_25mhz);
        check_cnt++; if (n8 - b8 !== 512) $display("FAIL single_writes8: got %0d want 512", n8 - b8); else pass_cnt++;
        check_cnt++; if (nm - bm !== 128) $display("FAIL single_writes32: got %0d want 128", nm - bm); else pass_cnt++;
        for (int i = 0; i < 512; i++) begin
            int idx = b8 + i;
            if (w8[idx[11:0]] !== 8'(i)) bad++;
        end
        check_cnt++; if (bad !== 0) $display("FAIL single_order8: got %0d bad bytes want 0", bad); else pass_cnt++;
        check_cnt++; if (wm[bm[9:0]] !== 32'h00010203) $display("FAIL single_word_msb: got %h want 00010203", wm[bm[9:0]]); else pass_cnt++;
        check_cnt++; if (wl[bl[9:0]] !== 32'h03020100) $display("FAIL single_word_lsb: got %h want 03020100", wl[bl[9:0]]); else pass_cnt++;
        check_cnt++; if (rd_rises - brd !== 1) $display("FAIL single_rd_count: got %0d want 1", rd_rises - brd); else pass_cnt++;
        check_cnt++; if (done_cnt - bd !== 1) $display("FAIL single_done_count: got %0d want 1", done_cnt - bd); else pass_cnt++;
    endtask

    task automatic test_pack;
        int bm = nm, bl = nl, bad = 0;
        pulse_start(32'd2, 16'd1);
        serve_sector(1, a8, al, ok);
        wait_done(seen);
        repeat (3) @(negedge clk_25mhz);
        check_cnt++; if (seen !== 1'b1) $display("FAIL pack_done: got %b want 1", seen); else pass_cnt++;
        check_cnt++; if (wm[bm[9:0]] !== 32'h11223344) $display("FAIL pack_msb_first: got %h want 11223344", wm[bm[9:0]]); else pass_cnt++;
        check_cnt++; if (wl[bl[9:0]] !== 32'h44332211) $display("FAIL pack_lsb_first: got %h want 44332211", wl[bl[9:0]]); else pass_cnt++;
        for (int i = 0; i < 128; i++) begin
            int idx = bm + i;
            if (wm[idx[9:0]] !== 32'h11223344) bad++;
        end
        check_cnt++; if (bad !== 0 || nm - bm !== 128) $display("FAIL pack_all_words: got %0d bad of %0d want 0 of 128", bad, nm - bm); else pass_cnt++;
    endtask

    task automatic test_wrap;
        int b8 = n8, bm = nm, bd = done_cnt, brd = rd_rises;
        logic [31:0] exp8, expl;
        pulse_start(32'hFFFF_FFFF, 16'd3);
        for (int s = 0; s < 3; s++) begin
            case (s)
                0:       begin exp8 = 32'hFFFF_FE00; expl = 32'hFFFF_FFFF; end
                1:       begin exp8 = 32'h0000_0000; expl = 32'h0000_0000; end
                default: begin exp8 = 32'h0000_0200; expl = 32'h0000_0001; end
            endcase
            serve_sector(0, a8, al, ok);
            check_cnt++; if (ok !== 1'b1 || a8 !== exp8) $display("FAIL wrap_addr_sdsc%0d: got %h want %h", s, a8, exp8); else pass_cnt++;
            check_cnt++; if (al !== expl) $display("FAIL wrap_addr_sdhc%0d: got %h want %h", s, al, expl); else pass_cnt++;
            if (s < 2) begin
                check_cnt++; if (done_cnt - bd !== 0) $display("FAIL wrap_early_done%0d: got %0d want 0", s, done_cnt - bd); else pass_cnt++;
            end
        end
        wait_done(seen);
        repeat (3) @(negedge clk_25mhz);
        check_cnt++; if (n8 - b8 !== 1536) $display("FAIL wrap_writes8: got %0d want 1536", n8 - b8); else pass_cnt++;
        check_cnt++; if (nm - bm !== 384) $display("FAIL wrap_writes32: got %0d want 384", nm - bm); else pass_cnt++;
        check_cnt++; if (done_cnt - bd !== 1) $display("FAIL wrap_done_count: got %0d want 1", done_cnt - bd); else pass_cnt++;
        check_cnt++; if (rd_rises - brd !== 3) $display("FAIL wrap_rd_count: got %0d want 3", rd_rises - brd); else pass_cnt++;
    endtask

    task automatic test_fifo_space;
        int b8 = n8, brd = rd_rises;
        fifo_space = 10'd100;
        pulse_start(32'd40, 16'd1);
        repeat (20) @(negedge clk_25mhz);
        check_cnt++; if (sd_rd_a !== 1'b0 || rd_rises - brd !== 0) $display("FAIL space_hold_rd: got %b/%0d want 0/0", sd_rd_a, rd_rises - brd); else pass_cnt++;
        check_cnt++; if (busy_a !== 1'b1) $display("FAIL space_hold_busy: got %b want 1", busy_a); else pass_cnt++;
        fifo_space = 10'd512;
        for (int i = 0; i < 2 && sd_rd_a !== 1'b1; i++) @(negedge clk_25mhz);
        check_cnt++; if (sd_rd_a !== 1'b1) $display("FAIL space_release_rd: got %b want 1", sd_rd_a); else pass_cnt++;
        serve_sector(0, a8, al, ok);
        wait_done(seen);
        repeat (3) @(negedge clk_25mhz);
        check_cnt++; if (seen !== 1'b1 || n8 - b8 !== 512) $display("FAIL space_writes: got %0d done=%b want 512 done=1", n8 - b8, seen); else pass_cnt++;
    endtask

    task automatic test_zero_sectors;
        int brd = rd_rises;
        pulse_start(32'd9, 16'd0);
        check_cnt++; if ({busy_a, done_a} !== 2'b10) $display("FAIL zero_cycle1: got busy,done=%b want 10", {busy_a, done_a}); else pass_cnt++;
        @(negedge clk_25mhz);
        check_cnt++; if ({busy_a, done_a} !== 2'b11) $display("FAIL zero_cycle2: got busy,done=%b want 11", {busy_a, done_a}); else pass_cnt++;
`ifdef SD_LOADER_CHECKSUM_EN
        check_cnt++; if (checksum_a !== 16'h0) $display("FAIL zero_checksum: got %h want 0", checksum_a); else pass_cnt++;
`endif
        // start coincident with done must be ignored
        start = 1'b1;
        @(negedge clk_25mhz);
        start = 1'b0;
        check_cnt++; if ({busy_a, done_a} !== 2'b00) $display("FAIL zero_cycle3: got busy,done=%b want 00", {busy_a, done_a}); else pass_cnt++;
        @(negedge clk_25mhz);
        check_cnt++; if ({busy_a, done_a} !== 2'b00) $display("FAIL start_on_done_ignored: got busy,done=%b want 00", {busy_a, done_a}); else pass_cnt++;
        check_cnt++; if (rd_rises - brd !== 0) $display("FAIL zero_no_rd: got %0d want 0", rd_rises - brd); else pass_cnt++;
    endtask

`ifdef SD_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        pulse_start(32'd3, 16'd1);
        serve_sector(2, a8, al, ok);
        wait_done(seen);
        check_cnt++; if (seen !== 1'b1 || checksum_a !== 16'hFE00) $display("FAIL checksum_ff: got %h want fe00", checksum_a); else pass_cnt++;
        check_cnt++; if (checksum_b !== 16'hFE00 || checksum_c !== 16'hFE00) $display("FAIL checksum_bc: got %h/%h want fe00", checksum_b, checksum_c); else pass_cnt++;
        repeat (2) @(negedge clk_25mhz);
    endtask
`endif

    task automatic test_timeout;
        int bd = done_cnt, cnt = 0;
        pulse_start(32'd7, 16'd1);
        wait_rd(ok);
        sd_ready = 1'b0;
        @(negedge clk_25mhz);
        send_bytes(0, 10);
        while (error_a !== 1'b1 && cnt < 1200) begin @(negedge clk_25mhz); cnt++; end
        check_cnt++; if (error_a !== 1'b1) $display("FAIL timeout_error: got %b want 1", error_a); else pass_cnt++;
        check_cnt++; if (cnt < 990 || cnt > 1000) $display("FAIL timeout_latency: got %0d want 990..1000", cnt); else pass_cnt++;
        check_cnt++; if (busy_a !== 1'b0 || sd_rd_a !== 1'b0) $display("FAIL timeout_busy: got busy,rd=%b%b want 00", busy_a, sd_rd_a); else pass_cnt++;
        sd_ready = 1'b1;
        repeat (5) @(negedge clk_25mhz);
        check_cnt++; if (error_a !== 1'b1 || done_cnt - bd !== 0) $display("FAIL timeout_sticky: got err=%b dones=%0d want 1/0", error_a, done_cnt - bd); else pass_cnt++;
        pulse_start(32'd0, 16'd0);
        check_cnt++; if (error_a !== 1'b0) $display("FAIL timeout_clear: got %b want 0", error_a); else pass_cnt++;
        @(negedge clk_25mhz);
        check_cnt++; if (done_a !== 1'b1) $display("FAIL timeout_restart_done: got %b want 1", done_a); else pass_cnt++;
        repeat (2) @(negedge clk_25mhz);
    endtask

    task automatic test_reset_abort;
        int b8, bd;
        pulse_start(32'd100, 16'd1);
        wait_rd(ok);
        sd_ready = 1'b0;
        @(negedge clk_25mhz);
        send_bytes(0, 5);
        reset = 1'b1;
        @(negedge clk_25mhz);
        @(negedge clk_25mhz);
        check_cnt++; if ({busy_a, sd_rd_a, fifo_wr_en_a} !== 3'b000) $display("FAIL abort_in_reset: got %b want 000", {busy_a, sd_rd_a, fifo_wr_en_a}); else pass_cnt++;
        reset = 1'b0;
        sd_ready = 1'b1;
        b8 = n8;
        bd = done_cnt;
        send_bytes(0, 8);
        repeat (20) @(negedge clk_25mhz);
        check_cnt++; if (n8 - b8 !== 0 || done_cnt - bd !== 0) $display("FAIL abort_quiet: got writes=%0d dones=%0d want 0/0", n8 - b8, done_cnt - bd); else pass_cnt++;
        check_cnt++; if (busy_a !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_a); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_sector();
        test_pack();
        test_wrap();
        test_fifo_space();
        test_zero_sectors();
`ifdef SD_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_timeout();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
